// File: rtl/seq_detect_ctrl.sv
// Serializes valid/ready bytes MSB-first into a Mealy detector and counts its match pulses.
// Latency: MSB on det_din the cycle after acceptance; in_ready only in IDLE or on the last bit.
module seq_detect_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              det_din,
    output logic              det_rst,
    input  logic              det_dout,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              clear,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              irq,
    output logic              busy,
    output logic              byte_done
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BW-1:0]     r_bit_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_irq;
    logic              r_byte_done;

    logic              w_shift;
    logic              w_last;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_irq_nxt;

    assign w_shift   = (r_state == S_SHIFT);
    assign w_last    = w_shift && (r_bit_cnt == LAST);

    assign in_ready  = (r_state == S_IDLE) || w_last;
    assign busy      = w_shift;
    assign det_rst   = !w_shift;
    assign det_din   = w_shift && r_shift[DATA_W-1];
    assign match_cnt = r_cnt;
    assign irq       = r_irq;
    assign byte_done = r_byte_done;

    // Reloading on the last bit keeps the detector out of reset, so matches span bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_INIT;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= w_last;
            case (r_state)
                S_INIT: r_state <= S_IDLE;
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift   <= in_data;
                        r_bit_cnt <= '0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_bit_cnt == LAST) begin
                        r_bit_cnt <= '0;
                        if (in_valid) begin
                            r_shift <= in_data;
                        end else begin
                            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    // Clear beats a coincident match; irq compares the post-update (possibly saturated) count.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clear) begin
            w_cnt_nxt = '0;
        end else if (w_shift && det_dout && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    assign w_irq_nxt = !clear && (r_irq || ((cfg_thresh != '0) && (w_cnt_nxt >= cfg_thresh)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_irq <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_irq <= w_irq_nxt;
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: two instances (8-bit and 2-bit counters) each driving a behavioural 0110 Mealy detector.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] cfg_thresh = 8'd2;
    logic [1:0] cfg_thresh_b = 2'd0;
    logic       clear = 1'b0;

    logic       in_ready, det_din, det_rst, det_dout, irq, busy, byte_done;
    logic [7:0] match_cnt;
    logic       in_ready_b, det_din_b, det_rst_b, det_dout_b, irq_b, busy_b, byte_done_b;
    logic [1:0] match_cnt_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_detect_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .det_din(det_din), .det_rst(det_rst), .det_dout(det_dout), .cfg_thresh(cfg_thresh),
        .clear(clear), .match_cnt(match_cnt), .irq(irq), .busy(busy), .byte_done(byte_done)
    );

    seq_detect_ctrl #(.DATA_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
        .det_din(det_din_b), .det_rst(det_rst_b), .det_dout(det_dout_b), .cfg_thresh(cfg_thresh_b),
        .clear(clear), .match_cnt(match_cnt_b), .irq(irq_b), .busy(busy_b), .byte_done(byte_done_b)
    );

    // Mealy 0110 detector: last three bits plus how many bits seen since its reset.
    logic [2:0] h_a = 3'b000, h_b = 3'b000;
    logic [1:0] n_a = 2'd0,   n_b = 2'd0;
    always @(posedge clk) begin
        if (det_rst) begin h_a <= 3'b000; n_a <= 2'd0; end
        else begin h_a <= {h_a[1:0], det_din}; if (n_a != 2'd3) n_a <= n_a + 2'd1; end
        if (det_rst_b) begin h_b <= 3'b000; n_b <= 2'd0; end
        else begin h_b <= {h_b[1:0], det_din_b}; if (n_b != 2'd3) n_b <= n_b + 2'd1; end
    end
    assign det_dout   = !det_rst   && (n_a == 2'd3) && (h_a == 3'b011) && !det_din;
    assign det_dout_b = !det_rst_b && (n_b == 2'd3) && (h_b == 3'b011) && !det_din_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: accepted bytes and their acceptance edge in, serialized bytes out.
    logic [7:0] exp_q[$];
    int         t_q[$];
    logic [7:0] got_q[$];
    logic [7:0] asm_byte = 8'h00;
    int         nb = 0;
    logic [7:0] e_byte, g_byte;
    int         t_acc;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete(); t_q.delete(); got_q.delete(); nb = 0;
        end else begin
            if (busy) begin
                asm_byte = {asm_byte[6:0], det_din};
                nb++;
                if (nb == 8) begin got_q.push_back(asm_byte); nb = 0; end
            end
            if (byte_done) begin
                chk("bd_pending", (exp_q.size() != 0) && (got_q.size() != 0), 1);
                if ((exp_q.size() != 0) && (got_q.size() != 0)) begin
                    e_byte = exp_q.pop_front();
                    g_byte = got_q.pop_front();
                    t_acc  = t_q.pop_front();
                    chk("serial_byte", g_byte, e_byte);
                    chk("byte_done_lat", cyc - t_acc, 8);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                t_q.push_back(cyc + 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        bit done = 0;
        int tries = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!done && tries < 40) begin
            if (in_ready) begin step(); acc_cyc = cyc; done = 1; end
            else begin step(); tries++; end
        end
        if (!done) chk("accept_timeout", in_ready, 1);
    endtask

    task automatic do_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    int a0;

    initial begin
        // Reset state
        #1 reset = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_det_rst", det_rst, 1);
        chk("rst_det_din", det_din, 0);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_irq", irq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_byte_done", byte_done, 0);
        repeat (2) step();
        reset = 1'b1;
        #1 chk("init_in_ready", in_ready, 0);
        step();
        chk("idle_in_ready", in_ready, 1);

        // Single byte 0x66, threshold 2
        drive_byte(8'h66);
        in_valid = 1'b0;
        chk("t1_msb", det_din, 0);
        chk("t1_busy", busy, 1);
        repeat (7) step();
        chk("t1_last_ready", in_ready, 1);
        chk("t1_cnt_mid", match_cnt, 1);
        chk("t1_irq_mid", irq, 0);
        step();
        chk("t1_cnt", match_cnt, 2);
        chk("t1_irq", irq, 1);
        chk("t1_byte_done", byte_done, 1);
        chk("t1_det_rst", det_rst, 1);
        cfg_thresh = 8'd200;
        step();
        chk("irq_sticky", irq, 1);
        cfg_thresh = 8'd2;

        // Back-to-back 0x03, 0x00: cross-byte match
        do_clear();
        chk("clr_cnt", match_cnt, 0);
        chk("clr_irq", irq, 0);
        drive_byte(8'h03);
        a0 = acc_cyc;
        drive_byte(8'h00);
        in_valid = 1'b0;
        chk("t2_no_bubble", acc_cyc - a0, 8);
        repeat (10) step();
        chk("t2_cnt", match_cnt, 1);

        // Bubble between bytes resets the detector
        do_clear();
        drive_byte(8'h03);
        in_valid = 1'b0;
        repeat (8) step();
        chk("t3_gap_busy", busy, 0);
        chk("t3_gap_det_rst", det_rst, 1);
        step();
        chk("t3_gap2_det_rst", det_rst, 1);
        drive_byte(8'h00);
        in_valid = 1'b0;
        repeat (10) step();
        chk("t3_cnt", match_cnt, 0);

        // Clear collides with the 6th match
        do_clear();
        drive_byte(8'h66);
        drive_byte(8'h66);
        drive_byte(8'h66);
        repeat (7) step();
        chk("t4_cnt_pre", match_cnt, 5);
        chk("t4_irq_pre", irq, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("t4_cnt_clr", match_cnt, 0);
        chk("t4_irq_clr", irq, 0);
        repeat (4) step();
        chk("t4_cnt_resume", match_cnt, 1);
        repeat (5) step();
        chk("t4_cnt_end", match_cnt, 2);

        // Saturation on the 2-bit instance, irq disabled there
        do_clear();
        drive_byte(8'h66);
        drive_byte(8'h66);
        in_valid = 1'b0;
        repeat (10) step();
        chk("t5_cnt_sat", match_cnt_b, 3);
        chk("t5_irq_dis", irq_b, 0);
        chk("t5_cnt_wide", match_cnt, 4);

        // Async reset during the 4th bit
        drive_byte(8'h66);
        in_valid = 1'b0;
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        chk("t6_in_ready", in_ready, 0);
        chk("t6_det_rst", det_rst, 1);
        chk("t6_cnt", match_cnt, 0);
        chk("t6_busy", busy, 0);
        step();
        reset = 1'b1;
        #1 chk("t6_init_ready", in_ready, 0);
        step();
        chk("t6_idle_ready", in_ready, 1);
        drive_byte(8'h66);
        in_valid = 1'b0;
        repeat (10) step();
        chk("t6_cnt_after", match_cnt, 2);
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Byte-stream sequencer for the team's serial Mealy pattern detector (din/dout, one bit per clock, active-high synchronous reset).
- Accepts bytes over a valid/ready handshake and serializes them MSB-first into the detector.
- Holds the detector in reset whenever no bit is being presented, and counts match pulses.
- Raises a sticky interrupt when the match count reaches a programmable threshold.

Parameters:
- DATA_W, 8, byte width in bits (≥2).
- CNT_W, 8, match counter and threshold width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream byte valid
- in_data  in  DATA_W  upstream byte
- in_ready  out  1  controller accepts byte this cycle
- det_din  out  1  serial bit to detector din
- det_rst  out  1  detector reset, active-high
- det_dout  in  1  detector Mealy output (combinational from det_din and detector state)
- cfg_thresh  in  CNT_W  irq threshold; 0 disables irq
- clear  in  1  synchronous clear of count and irq
- match_cnt  out  CNT_W  saturating match count
- irq  out  1  sticky, threshold reached
- busy  out  1  high in SHIFT
- byte_done  out  1  one-cycle pulse after last bit of a byte is presented

Behaviour:
- Reset (reset=0, async):
  - state=INIT, in_ready=0, det_rst=1, det_din=0.
  - match_cnt=0, irq=0, busy=0, byte_done=0, shift reg=0, bit_cnt=0.
- States:
  - INIT: one cycle after reset release, det_rst=1, then IDLE.
  - IDLE: in_ready=1, det_rst=1, det_din=0. in_valid=1 → load shift reg, bit_cnt=0, go to SHIFT.
  - SHIFT: det_rst=0, det_din=shift_reg[DATA_W-1], busy=1. Each cycle shift left by 1 and bit_cnt++.
- Last bit (bit_cnt==DATA_W-1):
  - in_ready=1 in this cycle.
  - in_valid=1: reload, bit_cnt=0, stay in SHIFT. No bubble; detector state is kept, so cross-byte matches count.
  - in_valid=0: go to IDLE. det_rst=1 from the next cycle, so cross-byte continuity is lost.
- Handshake:
  - Transfer when in_valid && in_ready.
  - in_ready is combinational from state/bit_cnt only, never from in_valid.
  - in_data is ignored when no transfer occurs.
- Latency:
  - Byte accepted at edge T → MSB on det_din in cycle T+1, LSB in cycle T+DATA_W.
  - byte_done pulses in cycle T+DATA_W+1.
- det_din, det_rst, in_ready and busy are decoded from registered state only.
- Match counting:
  - det_dout sampled in every SHIFT cycle.
  - det_dout=1 → match_cnt+1 at the next edge, saturating at 2^CNT_W-1.
  - det_dout is ignored outside SHIFT.
- irq:
  - Set at the edge where match_cnt becomes ≥ cfg_thresh, with cfg_thresh≠0.
  - Remains set until clear or reset, even if cfg_thresh changes afterwards.
- clear:
  - Forces match_cnt=0 and irq=0 at the next edge.
  - Wins over a simultaneous match; that match is dropped.
  - Does not affect the state machine or the shift.
- Saturation: count holds at max; irq is still evaluated against the held value.
- Reset mid-byte: the remaining bits are discarded; the sequence restarts at INIT.

Test Plan:
- Single byte, no overlap: send 0x66 (0110_0110) after IDLE, 0110 detector, cfg_thresh=2 → det_din 0,1,1,0,0,1,1,0 in the 8 cycles after acceptance; match_cnt=2; irq=1 one cycle after the 2nd match; byte_done pulse at T+9.
- Back-to-back across boundary: 0x03 then 0x00, in_valid held high → in_ready=1 on the last bit of 0x03, zero-bubble reload; match_cnt=1 (match on first bit of second byte).
- Bubble breaks continuity: 0x03, in_valid low for 2 cycles, then 0x00 → det_rst=1 during the gap; match_cnt=0; busy low during the gap.
- Clear vs match collision: assert clear in the same cycle det_dout=1 with match_cnt=5 → match_cnt=0, irq=0; subsequent matches resume counting from 0.
- Saturation and disable: CNT_W=2, cfg_thresh=0, send 0x66 twice (4 matches) → match_cnt sticks at 3; irq stays 0.
- Async reset mid-byte: drive reset=0 during the 4th bit of 0x66 → immediately in_ready=0, det_rst=1, match_cnt=0; after release, INIT for 1 cycle, then in_ready=1.
